// File: rtl/sync_down_counter.sv
// -----------------------------------------------------------------------------
// sync_down_counter
//
// Synchronous, presettable modulo down counter. All state is held in
// registers clocked by clk. The counter has two modes:
//   - continuous: it wraps from 0 to the top count and pulses borrow once.
//   - one-shot: it stops at 0, enters HALT and sets a sticky done flag.
// It feeds timebase and delay logic in the counter/timer section.
// -----------------------------------------------------------------------------
module sync_down_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             borrow,
    output logic             done,
    output logic             zero
);

    // The clamp compare is one bit wider than the counter. This keeps it
    // correct when MOD == 2**WIDTH: in that case MOD does not fit in WIDTH
    // bits, and no load value can be out of range.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MOD - 1);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] count_reg,  count_next;
    logic             borrow_reg, borrow_next;
    logic             done_reg,   done_next;

    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_clamped;

    assign load_ext     = {1'b0, load_value};
    assign load_clamped = (load_ext >= MOD_EXT) ? MAX_COUNT : load_value;

    // -------------------------------------------------------------------------
    // State register. clear acts immediately and does not wait for clk.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg  <= ST_COUNT;
            count_reg  <= '0;
            borrow_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            borrow_reg <= borrow_next;
            done_reg   <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. load beats enable. borrow defaults low, so it only
    // lasts for the one cycle after a wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        borrow_next = 1'b0;
        done_next   = done_reg;

        if (load) begin
            count_next = load_clamped;
            state_next = ST_COUNT;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_COUNT: begin
                    if (enable) begin
                        if (count_reg > WIDTH'(1)) begin
                            count_next = count_reg - WIDTH'(1);
                        end else if (count_reg == WIDTH'(1)) begin
                            count_next = '0;
                            if (oneshot) begin
                                state_next = ST_HALT;
                                done_next  = 1'b1;
                            end
                        end else begin
                            // The count is already 0. In one-shot mode it
                            // halts without wrapping. Otherwise it wraps.
                            if (oneshot) begin
                                state_next = ST_HALT;
                                done_next  = 1'b1;
                            end else begin
                                count_next  = MAX_COUNT;
                                borrow_next = 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // Frozen until a load or clear; enable has no effect here.
                    count_next = '0;
                    done_next  = 1'b1;
                end
                default: begin
                    state_next = ST_COUNT;
                end
            endcase
        end
    end

    assign count  = count_reg;
    assign borrow = borrow_reg;
    assign done   = done_reg;
    assign zero   = (count_reg == '0);

endmodule
